// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - PC owner, imem initiator and in-order fetch buffer feeding decode.
// Optional misaligned-redirect trap is enabled with `define ALIGN_CHECK_EN.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_ir,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_ir,
  output logic [31:0] out_pc,
  output logic [31:0] out_pc_plus4
`ifdef ALIGN_CHECK_EN
  ,
  output logic        fetch_addr_err
`endif
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  logic [31:0]      pc_q, pc_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [31:0]      pc_buf_q [FIFO_DEPTH];
  logic [31:0]      ir_buf_q [FIFO_DEPTH];

  logic full;
  logic fetch_blocked;
  logic push_en;
  logic pop_en;

`ifdef ALIGN_CHECK_EN
  logic err_q, err_d;

  // Sticky: once a misaligned target is seen, fetch stays frozen until reset.
  always_comb begin
    err_d = err_q;
    if (redirect_valid && (redirect_pc[1:0] != 2'b00)) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign fetch_blocked  = err_q;
  assign fetch_addr_err = err_q;
`else
  assign fetch_blocked = 1'b0;
`endif

  // Fullness uses the count before this cycle's pop, so a full buffer never refills in the pop cycle.
  assign full    = (count_q == DEPTH_C);
  assign push_en = !redirect_valid && !full && !fetch_blocked;
  assign pop_en  = !redirect_valid && out_valid && out_ready;

  assign imem_addr    = pc_q;
  assign out_valid    = (count_q != '0);
  assign out_ir       = ir_buf_q[rd_ptr_q];
  assign out_pc       = pc_buf_q[rd_ptr_q];
  assign out_pc_plus4 = out_pc + 32'd4;

  always_comb begin
    pc_d     = pc_q;
    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    if (redirect_valid) begin
      pc_d     = redirect_pc;
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end else begin
      if (push_en) begin
        pc_d     = pc_q + 32'd4;
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop_en) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({push_en, pop_en})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q     <= RESET_PC;
      count_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
    end else begin
      pc_q     <= pc_d;
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        pc_buf_q[i] <= '0;
        ir_buf_q[i] <= '0;
      end
    end else if (push_en) begin
      pc_buf_q[wr_ptr_q] <= pc_q;
      ir_buf_q[wr_ptr_q] <= imem_ir;
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// tb/tb_instruction_fetch.sv - scoreboard bench for instruction_fetch: directed cases plus random ready/redirect traffic.
module tb_instruction_fetch;

  localparam logic [31:0] RESET_PC   = 32'h0000_0000;
  localparam int          FIFO_DEPTH = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] imem_addr;
  logic [31:0] imem_ir;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_ir;
  logic [31:0] out_pc;
  logic [31:0] out_pc_plus4;
`ifdef ALIGN_CHECK_EN
  logic        fetch_addr_err;
`endif

  logic [31:0] mem [0:255];
  logic [31:0] exp_q [$];
  logic [31:0] mon_e;
  int checks = 0;
  int failures = 0;

  assign imem_ir = mem[imem_addr[9:2]];

  always #5 clk = ~clk;

  instruction_fetch #(
    .RESET_PC  (RESET_PC),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .imem_addr     (imem_addr),
    .imem_ir       (imem_ir),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_ir        (out_ir),
    .out_pc        (out_pc),
    .out_pc_plus4  (out_pc_plus4)
`ifdef ALIGN_CHECK_EN
    ,
    .fetch_addr_err(fetch_addr_err)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Expected delivery order after a (re)start: consecutive words from the start address.
  function automatic void restart_stream(input logic [31:0] start);
    exp_q.delete();
    for (int i = 0; i < 128; i++) exp_q.push_back(start + (32'(i) << 2));
  endfunction

  always @(negedge clk) begin
    if (!reset && out_valid && out_ready && !redirect_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL scoreboard_empty actual=%h required=none", out_pc);
      end else begin
        mon_e = exp_q.pop_front();
        check("mon_pc", out_pc, mon_e);
        check("mon_ir", out_ir, mem[mon_e[9:2]]);
        check("mon_pc_plus4", out_pc_plus4, mon_e + 32'd4);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic rdy);
    reset = 1'b1;
    redirect_valid = 1'b0;
    out_ready = rdy;
    restart_stream(RESET_PC);
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic do_redirect(input logic [31:0] pc);
    redirect_valid = 1'b1;
    redirect_pc = pc;
    restart_stream(pc);
    tick();
    redirect_valid = 1'b0;
  endtask

  logic [31:0] t1_ir [4];
  logic [31:0] rpc;
  int seg;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    mem[0] = 32'h11; mem[1] = 32'h22; mem[2] = 32'h33; mem[3] = 32'h44;
    t1_ir[0] = 32'h11; t1_ir[1] = 32'h22; t1_ir[2] = 32'h33; t1_ir[3] = 32'h44;

    // Reset values, then streaming from RESET_PC with ready high
    restart_stream(RESET_PC);
    tick();
    tick();
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_out_ir", out_ir, 32'h0);
    check("rst_out_pc", out_pc, 32'h0);
    check("rst_out_pc_plus4", out_pc_plus4, 32'h4);
    check("rst_imem_addr", imem_addr, RESET_PC);
    out_ready = 1'b1;
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t1_valid", 32'(out_valid), 32'h1);
      check("t1_pc", out_pc, 32'(i) * 4);
      check("t1_ir", out_ir, t1_ir[i]);
      check("t1_pc_plus4", out_pc_plus4, 32'(i) * 4 + 32'd4);
    end

    // Full-buffer stall with ready low, then drain without skips or duplicates
    do_reset(1'b0);
    tick();
    tick();
    tick();
    check("t2_imem_addr_hold", imem_addr, 32'h8);
    check("t2_valid", 32'(out_valid), 32'h1);
    check("t2_pc0", out_pc, 32'h0);
    out_ready = 1'b1;
    tick();
    check("t2_pc1", out_pc, 32'h4);
    tick();
    check("t2_pc2", out_pc, 32'h8);

    // Redirect while full with ready high: nothing popped, stream restarts at 0x40
    out_ready = 1'b0;
    tick();
    tick();
    tick();
    check("t3_full_valid", 32'(out_valid), 32'h1);
    out_ready = 1'b1;
    do_redirect(32'h40);
    check("t3_valid_after_redirect", 32'(out_valid), 32'h0);
    check("t3_imem_addr", imem_addr, 32'h40);
    tick();
    check("t3_valid", 32'(out_valid), 32'h1);
    check("t3_pc", out_pc, 32'h40);
    check("t3_ir", out_ir, mem[16]);

    // Asynchronous reset between edges
    tick();
    tick();
    #3;
    reset = 1'b1;
    #1;
    check("t4_async_valid", 32'(out_valid), 32'h0);
    check("t4_async_imem_addr", imem_addr, RESET_PC);
    restart_stream(RESET_PC);
    tick();
    reset = 1'b0;
    tick();
    check("t4_restart_valid", 32'(out_valid), 32'h1);
    check("t4_restart_pc", out_pc, RESET_PC);

    // Address wrap at the top of the 32-bit space
    do_redirect(32'hFFFF_FFF8);
    tick();
    check("t5_pc_fff8", out_pc, 32'hFFFF_FFF8);
    tick();
    check("t5_pc_fffc", out_pc, 32'hFFFF_FFFC);
    check("t5_plus4_wrap", out_pc_plus4, 32'h0);
    tick();
    check("t5_pc_wrap", out_pc, 32'h0);
    check("t5_ir_wrap", out_ir, 32'h11);

    // Misaligned redirect
    do_redirect(32'h42);
`ifdef ALIGN_CHECK_EN
    check("t6_err_set", 32'(fetch_addr_err), 32'h1);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("t6_blocked_valid", 32'(out_valid), 32'h0);
    end
    check("t6_pc_hold", imem_addr, 32'h42);
    do_reset(1'b1);
    check("t6_err_cleared", 32'(fetch_addr_err), 32'h0);
`else
    tick();
    check("t6_misaligned_valid", 32'(out_valid), 32'h1);
    check("t6_misaligned_pc", out_pc, 32'h42);
    check("t6_misaligned_ir", out_ir, mem[16]);
`endif

    // Random ready/redirect traffic against the scoreboard
    do_redirect(32'h100);
    seg = 0;
    for (int c = 0; c < 3000; c++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      seg++;
      if ($urandom_range(0, 19) == 0 || seg >= 100) begin
        seg = 0;
        if ($urandom_range(0, 7) == 0) rpc = 32'hFFFF_FF00 + (32'($urandom_range(0, 63)) << 2);
        else rpc = 32'($urandom_range(0, 255)) << 2;
        do_redirect(rpc);
      end else begin
        tick();
      end
    end
    out_ready = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
